red_blob_tracker: RTL

Per-frame red-marker locator on the VGA pixel path, sitting between the VGA controller's pixel/coordinate outputs and the sound controller. Each active pixel is classified as "marker red" against programmable thresholds. Coordinate sums and a pixel count are accumulated over the frame. At frame end a sequential divider produces the marker centroid, a found flag and a one-hot horizontal zone that drives sound selection.

---
 rtl/red_blob_tracker_if.sv | 25 ++
 rtl/red_blob_tracker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/red_blob_tracker_if.sv
// red_blob_tracker_if: pixel stream in, per-frame marker result out
interface red_blob_tracker_if;
  logic        i_valid;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic [7:0]  i_r;
  logic [7:0]  i_g;
  logic [7:0]  i_b;
  logic        i_frame_end;
  logic        o_valid;
  logic        o_found;
  logic [9:0]  o_center_x;
  logic [9:0]  o_center_y;
  logic [2:0]  o_zone;
  logic [18:0] o_count;
  logic        o_overrun;
  modport master (
    output i_valid, i_x, i_y, i_r, i_g, i_b, i_frame_end,
    input  o_valid, o_found, o_center_x, o_center_y, o_zone, o_count, o_overrun
  );
  modport slave (
    input  i_valid, i_x, i_y, i_r, i_g, i_b, i_frame_end,
    output o_valid, o_found, o_center_x, o_center_y, o_zone, o_count, o_overrun
  );
endinterface

// File: rtl/red_blob_tracker.sv
// red_blob_tracker: per-frame red marker centroid, found flag and horizontal zone
module red_blob_tracker #(
  parameter logic [7:0]  R_MIN      = 8'd160,
  parameter logic [7:0]  MARGIN     = 8'd48,
  parameter logic [18:0] MIN_PIXELS = 19'd64,
  parameter logic [9:0]  ZONE1      = 10'd213,
  parameter logic [9:0]  ZONE2      = 10'd427
) (
  input logic clk,
  input logic rst,
  red_blob_tracker_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, DONE} state_t;
  state_t      r_state, w_next;
  logic [27:0] r_sum_x, r_sum_y, r_snap_x, r_snap_y, r_dvd;
  logic [18:0] r_cnt, r_snap_cnt, r_rem;
  logic [4:0]  r_step;
  logic [9:0]  r_qx, r_qy, r_cx, r_cy;
  logic [2:0]  r_zone;
  logic [18:0] r_count;
  logic        r_valid, r_found, r_overrun;
  logic        w_hit, w_start, w_div, w_last, w_ge, w_found;
  logic [28:0] w_sx_sum, w_sy_sum;
  logic [19:0] w_cnt_sum, w_rem_sh;
  logic [27:0] w_sx_acc, w_sy_acc, w_quo;
  logic [18:0] w_cnt_acc, w_rem_nx;
  logic [2:0]  w_zone;
  assign w_hit = bus.i_valid && (bus.i_r >= R_MIN)
              && ({1'b0, bus.i_r} >= {1'b0, bus.i_g} + {1'b0, MARGIN})
              && ({1'b0, bus.i_r} >= {1'b0, bus.i_b} + {1'b0, MARGIN});
  assign w_sx_sum  = {1'b0, r_sum_x} + {19'd0, bus.i_x};
  assign w_sy_sum  = {1'b0, r_sum_y} + {19'd0, bus.i_y};
  assign w_cnt_sum = {1'b0, r_cnt} + 20'd1;
  assign w_sx_acc  = !w_hit ? r_sum_x : w_sx_sum[28] ? '1 : w_sx_sum[27:0];
  assign w_sy_acc  = !w_hit ? r_sum_y : w_sy_sum[28] ? '1 : w_sy_sum[27:0];
  assign w_cnt_acc = !w_hit ? r_cnt : w_cnt_sum[19] ? '1 : w_cnt_sum[18:0];
  assign w_start   = (r_state == ACCUM) && bus.i_frame_end;
  assign w_div     = (r_state == DIV_X) || (r_state == DIV_Y);
  assign w_last    = r_step == 5'd27;
  assign w_rem_sh  = {r_rem, r_dvd[27]};
  assign w_ge      = w_rem_sh >= {1'b0, r_snap_cnt};
  assign w_rem_nx  = w_ge ? 19'(w_rem_sh - {1'b0, r_snap_cnt}) : w_rem_sh[18:0];
  assign w_quo     = {r_dvd[26:0], w_ge};
  assign w_found   = r_snap_cnt >= MIN_PIXELS;
  assign w_zone    = r_qx < ZONE1 ? 3'b001 : r_qx < ZONE2 ? 3'b010 : 3'b100;
  assign bus.o_valid    = r_valid;
  assign bus.o_found    = r_found;
  assign bus.o_center_x = r_cx;
  assign bus.o_center_y = r_cy;
  assign bus.o_zone     = r_zone;
  assign bus.o_count    = r_count;
  assign bus.o_overrun  = r_overrun;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  // frame sequencing: accumulate, divide x then y, publish
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   w_next = bus.i_frame_end ? DIV_X : ACCUM;
      DIV_X:   w_next = w_last ? DIV_Y : DIV_X;
      DIV_Y:   w_next = w_last ? DONE : DIV_Y;
      default: w_next = ACCUM;
    endcase
  end
  // saturating accumulators; a frame end restarts them from the same-cycle pixel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (bus.i_frame_end) begin
      r_sum_x <= w_hit ? {18'd0, bus.i_x} : '0;
      r_sum_y <= w_hit ? {18'd0, bus.i_y} : '0;
      r_cnt   <= {18'd0, w_hit};
    end else begin
      r_sum_x <= w_sx_acc;
      r_sum_y <= w_sy_acc;
      r_cnt   <= w_cnt_acc;
    end
  // snapshot of the closing frame, taken only when the divider is free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_snap_x   <= '0;
      r_snap_y   <= '0;
      r_snap_cnt <= '0;
    end else if (w_start) begin
      r_snap_x   <= w_sx_acc;
      r_snap_y   <= w_sy_acc;
      r_snap_cnt <= w_cnt_acc;
    end
  // restoring divider, one quotient bit per cycle; x result then y result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_step <= '0;
      r_qx   <= '0;
      r_qy   <= '0;
    end else if (w_start) begin
      r_dvd  <= w_sx_acc;
      r_rem  <= '0;
      r_step <= '0;
    end else if (w_div) begin
      r_step <= w_last ? 5'd0 : r_step + 5'd1;
      r_rem  <= w_last ? 19'd0 : w_rem_nx;
      r_dvd  <= (w_last && r_state == DIV_X) ? r_snap_y : w_quo;
      if (w_last && r_state == DIV_X) r_qx <= w_quo[9:0];
      if (w_last && r_state == DIV_Y) r_qy <= w_quo[9:0];
    end
  // registered results, updated on the publish cycle; overrun is sticky
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid   <= 1'b0;
      r_found   <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_zone    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= r_state == DONE;
      if (r_state == DONE) begin
        r_count <= r_snap_cnt;
        r_found <= w_found;
        r_zone  <= w_found ? w_zone : 3'b000;
        if (w_found) begin
          r_cx <= r_qx;
          r_cy <= r_qy;
        end
      end
      if (bus.i_frame_end && r_state != ACCUM) r_overrun <= 1'b1;
    end
endmodule
